// File: rtl/dmem_pkg.sv
// Shared size encodings, FSM states and address checks for data_mem_ws.
// Define DMEM_MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Byte offset within the word after aligning down to the access size.
  function automatic logic [1:0] lane_offs(input logic [1:0] lo, input size_e s);
    case (s)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

  // Range is checked on the unaligned address so a straddling access always errs.
  function automatic logic access_err(input logic [31:0] a, input size_e s, input int depth);
    logic [32:0] last;
    if (s == SZ_ILL) return 1'b1;
    last = {1'b0, a} + {30'b0, size_bytes(s)} - 33'd1;
    if (last >= 33'(depth)) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (s == SZ_HALF && a[0]) return 1'b1;
    if (s == SZ_WORD && a[1:0] != 2'b00) return 1'b1;
`endif
    return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Big-endian lane steering: byte lane k (address base+k) lives in bits [31-8k -: 8].
// Misalignment handling is done upstream (DMEM_MISALIGN_TRAP_EN), offsets arrive aligned.
module dmem_lane_mux
  import dmem_pkg::*;
(
  input  size_e       w_size,
  input  logic [1:0]  w_offs,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wword,
  input  size_e       r_size,
  input  logic [1:0]  r_offs,
  input  logic [31:0] rword,
  output logic [31:0] rdata
);

  logic [31:0] rsh;

  assign rsh = rword << {r_offs, 3'b000};

  always_comb begin
    be    = 4'b0000;
    wword = 32'h0;
    case (w_size)
      SZ_BYTE: begin
        be    = 4'b1000 >> w_offs;
        wword = {wdata[7:0], 24'h0} >> {w_offs, 3'b000};
      end
      SZ_HALF: begin
        be    = w_offs[1] ? 4'b0011 : 4'b1100;
        wword = w_offs[1] ? {16'h0, wdata[15:0]} : {wdata[15:0], 16'h0};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    case (r_size)
      SZ_BYTE: rdata = {24'h0, rsh[31:24]};
      SZ_HALF: rdata = {16'h0, rsh[31:16]};
      SZ_WORD: rdata = rword;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ws.sv
// Byte-addressed data memory with a fixed number of wait states and big-endian lanes.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of aligning them down.
module data_mem_ws
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int WORD_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic [31:0]           addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  err
);

  // state   | meaning
  // ST_IDLE | no access outstanding, req accepted
  // ST_WAIT | wait-state countdown, req ignored
  // ST_DONE | ready pulse; write commits at the closing edge, req accepted

  localparam int AW = $clog2(MEM_DEPTH);

  logic [7:0]       mem [MEM_DEPTH];
  state_e           state;
  logic [CNT_W-1:0] cnt;

  logic        lat_wr;
  size_e       lat_size;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;

  logic        cur_wr;
  size_e       cur_size;
  logic [31:0] cur_addr;
  logic        cur_err;

  logic          wr_commit;
  logic          enter_done;
  logic [AW-1:0] w_base;
  logic [AW-1:0] r_base;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rword;
  logic [31:0]   rd_val;

  // With no wait states DONE is entered at the accepting edge, so the live inputs drive it.
  assign cur_wr   = (WAIT_STATES == 0) ? wr : lat_wr;
  assign cur_size = (WAIT_STATES == 0) ? size_e'(size) : lat_size;
  assign cur_addr = (WAIT_STATES == 0) ? addr : lat_addr;
  assign cur_err  = access_err(cur_addr, cur_size, MEM_DEPTH);
  assign lat_err  = access_err(lat_addr, lat_size, MEM_DEPTH);

  assign wr_commit  = (state == ST_DONE) && lat_wr && !lat_err;
  assign enter_done = (state == ST_WAIT) ? (cnt <= CNT_W'(1))
                                         : ((WAIT_STATES == 0) && req);

  assign w_base = {lat_addr[AW-1:2], 2'b00};
  assign r_base = {cur_addr[AW-1:2], 2'b00};

  // A read entering DONE on the same edge a write commits sees the new bytes.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rword[31-8*k -: 8] = mem[r_base | AW'(k)];
      if (wr_commit && (w_base == r_base) && be[3-k])
        rword[31-8*k -: 8] = wword[31-8*k -: 8];
    end
  end

  dmem_lane_mux u_lane_mux (
    .w_size (lat_size),
    .w_offs (lane_offs(lat_addr[1:0], lat_size)),
    .wdata  (lat_wdata),
    .be     (be),
    .wword  (wword),
    .r_size (cur_size),
    .r_offs (lane_offs(cur_addr[1:0], cur_size)),
    .rword  (rword),
    .rdata  (rd_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      lat_wr    <= 1'b0;
      lat_size  <= SZ_BYTE;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            lat_wr    <= wr;
            lat_size  <= size_e'(size);
            lat_addr  <= addr;
            lat_wdata <= 32'(wdata);
            if (WAIT_STATES == 0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_STATES);
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state <= ST_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Any errored access returns zero data, read or write.
      if (enter_done) begin
        ready <= 1'b1;
        busy  <= 1'b0;
        err   <= cur_err;
        if (cur_err)
          rdata <= '0;
        else if (!cur_wr)
          rdata <= WORD_WIDTH'(rd_val);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int k = 0; k < 4; k++)
        if (be[3-k]) mem[w_base | AW'(k)] <= wword[31-8*k -: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed plus random bench for data_mem_ws (WAIT_STATES=2, MEM_DEPTH=1024)
// against a byte-array model; honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_data_mem_ws;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mm [DEPTH];
  logic [31:0] m_rdata = 32'h0;

  data_mem_ws #(.MEM_DEPTH(DEPTH), .WORD_WIDTH(32), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wr    (wr),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    case (s)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] s);
    longint n;
    n = longint'(nb(s));
    if (n == 0) return 1'b1;
    if (longint'(a) + n - 1 >= DEPTH) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (longint'(a) % n != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Big-endian value of the size-aligned field at a.
  function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s);
    int n;
    int base;
    logic [31:0] v;
    n = nb(s);
    base = int'(a) - (int'(a) % n);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | {24'h0, mm[base+i]};
    return v;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int n;
    int base;
    n = nb(s);
    base = int'(a) - (int'(a) % n);
    for (int i = 0; i < n; i++) mm[base+i] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic do_acc(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    bit e;
    int cyc;
    e = m_err(a, sz);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 1;
    while (!ready && cyc < 16) begin
      chk({tag, " busy"}, {31'b0, busy}, 32'd1);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, LAT);
    chk({tag, " err"}, {31'b0, err}, {31'b0, e});
    if (e) m_rdata = 32'h0;
    else if (!w) m_rdata = m_read(a, sz);
    chk({tag, " rdata"}, rdata, m_rdata);
    chk({tag, " busy done"}, {31'b0, busy}, 32'd0);
    if (w && !e) m_write(a, sz, d);
    @(negedge clk);
    chk({tag, " ready pulse"}, {31'b0, ready}, 32'd0);
  endtask

  logic [7:0]  exp34 [4];
  logic [31:0] ra [4];
  logic [1:0]  rs [4];

  initial begin
    exp34 = '{8'h11, 8'h22, 8'h33, 8'h44};
    ra = '{32'd0, 32'd4, 32'd9, 32'd2};
    rs = '{2'd2, 2'd2, 2'd0, 2'd1};

    repeat (3) @(negedge clk);
    chk("reset ready", {31'b0, ready}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rst_n = 1'b1;

    for (int a = 0; a < 64; a += 4) do_acc(1'b1, 2'd2, a, $urandom, "init lo");
    for (int a = 1016; a < 1024; a += 4) do_acc(1'b1, 2'd2, a, $urandom, "init hi");

    // word write/read at 8, then byte view of the same field
    do_acc(1'b1, 2'd2, 32'd8, 32'h11223344, "w word 8");
    do_acc(1'b0, 2'd2, 32'd8, 32'h0, "r word 8");
    chk("word 8 const", rdata, 32'h11223344);
    for (int i = 0; i < 4; i++) begin
      do_acc(1'b0, 2'd0, 32'(8 + i), 32'h0, "r byte 8+i");
      chk("byte 8+i const", rdata, {24'h0, exp34[i]});
    end

    do_acc(1'b1, 2'd0, 32'd9, 32'hFFFF_FFAB, "w byte 9");
    do_acc(1'b0, 2'd1, 32'd8, 32'h0, "r half 8");
    chk("half 8 const", rdata, 32'h0000_11AB);
    do_acc(1'b0, 2'd0, 32'd10, 32'h0, "r byte 10");
    chk("byte 10 const", rdata, 32'h33);
    do_acc(1'b0, 2'd0, 32'd11, 32'h0, "r byte 11");
    chk("byte 11 const", rdata, 32'h44);

    // req held high for four reads; WAIT cycles present junk on the inputs
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = rs[0]; addr = ra[0];
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("b2b ready", {31'b0, ready}, {31'b0, k % 3 == 2});
      chk("b2b busy", {31'b0, busy}, {31'b0, k % 3 != 2});
      if (k % 3 == 2) begin
        m_rdata = m_read(ra[k/3], rs[k/3]);
        chk("b2b rdata", rdata, m_rdata);
        if (k / 3 < 3) begin
          wr = 1'b0; size = rs[k/3+1]; addr = ra[k/3+1];
        end else begin
          req = 1'b0;
        end
      end else begin
        wr = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
      end
    end
    @(negedge clk);
    chk("b2b idle ready", {31'b0, ready}, 32'd0);
    chk("b2b idle busy", {31'b0, busy}, 32'd0);

    // out of range and illegal size
    do_acc(1'b0, 2'd2, 32'd1022, 32'h0, "r word 1022");
    chk("oor err rdata", rdata, 32'h0);
    do_acc(1'b1, 2'd2, 32'd1022, 32'hDEADBEEF, "w word 1022");
    do_acc(1'b0, 2'd1, 32'd1022, 32'h0, "r half 1022");
    do_acc(1'b0, 2'd3, 32'd16, 32'h0, "r size 11");
    do_acc(1'b1, 2'd3, 32'd16, 32'hFFFFFFFF, "w size 11");
    do_acc(1'b0, 2'd2, 32'd16, 32'h0, "r word 16");

    // misaligned half write at 3
    do_acc(1'b1, 2'd1, 32'd3, 32'h0000BEEF, "w half 3");
    do_acc(1'b0, 2'd0, 32'd2, 32'h0, "r byte 2");
    do_acc(1'b0, 2'd0, 32'd3, 32'h0, "r byte 3");

    // reset one cycle after a write is accepted
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'd32; wdata = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    m_rdata = 32'h0;
    chk("abort ready", {31'b0, ready}, 32'd0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort err", {31'b0, err}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort no ready", {31'b0, ready}, 32'd0);
    end
    do_acc(1'b0, 2'd2, 32'd32, 32'h0, "r word 32 after abort");

    // randomized traffic over the initialised regions and just past the top
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  s;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1016, 1027))
                                      : 32'($urandom_range(0, 63));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_acc(1'($urandom), s, a, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
